// File: rtl/ddr_test_pkg.sv
// Shared definitions for the DDR AXI traffic generator: FSM state encoding,
// the LFSR polynomial, the default seed base and small pattern helpers.
package ddr_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_INIT = 3'd1,
        ST_WR_ADDR   = 3'd2,
        ST_WR_DATA   = 3'd3,
        ST_RD_ADDR   = 3'd4,
        ST_RD_DATA   = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Seed of iteration n is SEED_BASE + n.
    localparam logic [31:0] SEED_BASE = 32'hACE1_0000;

    // One Galois LFSR step.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        lfsr_step = {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
    endfunction

    // Pattern seed for a given iteration number.
    function automatic logic [31:0] seed_for_iter(input logic [15:0] iter);
        seed_for_iter = SEED_BASE + {16'h0000, iter};
    endfunction

endpackage

// File: rtl/pattern_gen.sv
// 32-bit data pattern source: incrementing counter or Galois LFSR.
// The current word is presented on o_word; i_adv steps to the next word.
module pattern_gen
    import ddr_test_pkg::*;
(
    input  logic        core_clk,
    input  logic        i_rst_n,
    input  logic        i_mode,
    input  logic        i_load,
    input  logic [31:0] i_seed,
    input  logic        i_adv,
    output logic [31:0] o_word
);

    logic [31:0] r_word;
    logic [31:0] w_load_val;
    logic [31:0] w_next;

    // Seed conditioning (LFSR cannot start at zero) and next-word selection.
    always_comb begin
        w_load_val = i_seed;
        w_next     = r_word + 32'd1;
        if (i_mode && (i_seed == 32'h0000_0000)) begin
            w_load_val = 32'h0000_0001;
        end else begin
            w_load_val = i_seed;
        end
        if (i_mode) begin
            w_next = lfsr_step(r_word);
        end else begin
            w_next = r_word + 32'd1;
        end
    end

    // Pattern state: load has priority over advance.
    always_ff @(posedge core_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word <= 32'h0000_0000;
        end else if (i_load) begin
            r_word <= w_load_val;
        end else if (i_adv) begin
            r_word <= w_next;
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/ddr_axi_traffic_gen.sv
// DDR AXI traffic generator: writes a pattern over an address range in
// fixed-length bursts, reads it back, compares every beat and counts
// mismatches. Optionally loops with a fresh seed per iteration.
module ddr_axi_traffic_gen
    import ddr_test_pkg::*;
#(
    parameter int                ADDR_W     = 28,
    parameter int                DATA_W     = 256,
    parameter int                BURST_LEN  = 16,
    parameter int                ADDR_STEP  = 128,
    parameter logic [ADDR_W-1:0] START_ADDR = 28'h000_0000,
    parameter logic [ADDR_W-1:0] END_ADDR   = 28'hFFF_FF80
)(
    input  logic                core_clk,
    input  logic                i_rst_n,
    input  logic                ddr_init_done,
    input  logic                i_start,
    input  logic                i_pat_sel,
    input  logic                i_loop_en,
    output logic [ADDR_W-1:0]   axi_awaddr,
    output logic [3:0]          axi_awlen,
    output logic                axi_awvalid,
    input  logic                axi_awready,
    output logic [DATA_W-1:0]   axi_wdata,
    output logic [DATA_W/8-1:0] axi_wstrb,
    output logic                axi_wvalid,
    output logic                axi_wlast,
    input  logic                axi_wready,
    output logic [ADDR_W-1:0]   axi_araddr,
    output logic [3:0]          axi_arlen,
    output logic                axi_arvalid,
    input  logic                axi_arready,
    input  logic [DATA_W-1:0]   axi_rdata,
    input  logic                axi_rvalid,
    input  logic                axi_rlast,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err_flag,
    output logic [15:0]         o_err_cnt,
    output logic [15:0]         o_iter_cnt
);

    localparam int                WORDS     = DATA_W / 32;
    localparam int                BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic              r_init_meta;
    logic              r_init_sync;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [BEAT_W-1:0] r_beat;
    logic [BEAT_W-1:0] w_beat_nxt;
    logic [15:0]       r_iter_cnt;
    logic [15:0]       w_iter_nxt;
    logic [15:0]       r_err_cnt;
    logic              r_err_flag;
    logic              r_mode;
    logic              w_clear;
    logic              w_wr_load;
    logic              w_rd_load;
    logic [31:0]       w_seed;
    logic [31:0]       w_wr_word;
    logic [31:0]       w_rd_word;
    logic              w_w_hs;
    logic              w_r_beat;
    logic              w_last_beat;
    logic              w_last_addr;
    logic              w_mismatch;
    logic              w_rlast_unused;

    // rlast is not used for burst framing; beats are counted instead.
    assign w_rlast_unused = axi_rlast;

    assign w_w_hs      = (r_state == ST_WR_DATA) && axi_wready;
    assign w_r_beat    = (r_state == ST_RD_DATA) && axi_rvalid;
    assign w_last_beat = (r_beat == LAST_BEAT);
    assign w_last_addr = (r_addr == END_ADDR);
    assign w_mismatch  = (axi_rdata != {WORDS{w_rd_word}});

    // Two-flop synchroniser for the asynchronous calibration-done flag.
    always_ff @(posedge core_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_init_meta <= 1'b0;
            r_init_sync <= 1'b0;
        end else begin
            r_init_meta <= ddr_init_done;
            r_init_sync <= r_init_meta;
        end
    end

    // Next-state, address/beat/iteration updates and generator reloads.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_beat_nxt  = r_beat;
        w_iter_nxt  = r_iter_cnt;
        w_clear     = 1'b0;
        w_wr_load   = 1'b0;
        w_rd_load   = 1'b0;
        w_seed      = seed_for_iter(r_iter_cnt);
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_state_nxt = ST_WAIT_INIT;
                    w_clear     = 1'b1;
                    w_iter_nxt  = 16'h0000;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_WAIT_INIT: begin
                if (r_init_sync) begin
                    w_state_nxt = ST_WR_ADDR;
                    w_addr_nxt  = START_ADDR;
                    w_beat_nxt  = {BEAT_W{1'b0}};
                    w_wr_load   = 1'b1;
                end else begin
                    w_state_nxt = ST_WAIT_INIT;
                end
            end
            ST_WR_ADDR: begin
                if (axi_awready) begin
                    w_state_nxt = ST_WR_DATA;
                    w_beat_nxt  = {BEAT_W{1'b0}};
                end else begin
                    w_state_nxt = ST_WR_ADDR;
                end
            end
            ST_WR_DATA: begin
                if (axi_wready && w_last_beat) begin
                    w_beat_nxt = {BEAT_W{1'b0}};
                    if (w_last_addr) begin
                        w_state_nxt = ST_RD_ADDR;
                        w_addr_nxt  = START_ADDR;
                        w_rd_load   = 1'b1;
                    end else begin
                        w_state_nxt = ST_WR_ADDR;
                        w_addr_nxt  = r_addr + ADDR_W'(ADDR_STEP);
                    end
                end else if (axi_wready) begin
                    w_beat_nxt = r_beat + {{(BEAT_W-1){1'b0}}, 1'b1};
                end else begin
                    w_state_nxt = ST_WR_DATA;
                end
            end
            ST_RD_ADDR: begin
                if (axi_arready) begin
                    w_state_nxt = ST_RD_DATA;
                    w_beat_nxt  = {BEAT_W{1'b0}};
                end else begin
                    w_state_nxt = ST_RD_ADDR;
                end
            end
            ST_RD_DATA: begin
                if (axi_rvalid && w_last_beat) begin
                    w_beat_nxt = {BEAT_W{1'b0}};
                    if (w_last_addr) begin
                        w_iter_nxt = r_iter_cnt + 16'd1;
                        if (i_loop_en) begin
                            w_state_nxt = ST_WR_ADDR;
                            w_addr_nxt  = START_ADDR;
                            w_wr_load   = 1'b1;
                            w_seed      = seed_for_iter(r_iter_cnt + 16'd1);
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_state_nxt = ST_RD_ADDR;
                        w_addr_nxt  = r_addr + ADDR_W'(ADDR_STEP);
                    end
                end else if (axi_rvalid) begin
                    w_beat_nxt = r_beat + {{(BEAT_W-1){1'b0}}, 1'b1};
                end else begin
                    w_state_nxt = ST_RD_DATA;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sequencer state: FSM, burst address, beat index and iteration count.
    always_ff @(posedge core_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= START_ADDR;
            r_beat     <= {BEAT_W{1'b0}};
            r_iter_cnt <= 16'h0000;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_beat     <= w_beat_nxt;
            r_iter_cnt <= w_iter_nxt;
        end
    end

    // Pattern mode latch and sticky error flag with saturating error count.
    always_ff @(posedge core_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode     <= 1'b0;
            r_err_flag <= 1'b0;
            r_err_cnt  <= 16'h0000;
        end else if (w_clear) begin
            r_mode     <= i_pat_sel;
            r_err_flag <= 1'b0;
            r_err_cnt  <= 16'h0000;
        end else if (w_r_beat && w_mismatch) begin
            r_err_flag <= 1'b1;
            if (r_err_cnt != 16'hFFFF) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    pattern_gen u_wr_gen (
        .core_clk (core_clk),
        .i_rst_n  (i_rst_n),
        .i_mode   (r_mode),
        .i_load   (w_wr_load),
        .i_seed   (w_seed),
        .i_adv    (w_w_hs),
        .o_word   (w_wr_word)
    );

    pattern_gen u_rd_gen (
        .core_clk (core_clk),
        .i_rst_n  (i_rst_n),
        .i_mode   (r_mode),
        .i_load   (w_rd_load),
        .i_seed   (w_seed),
        .i_adv    (w_r_beat),
        .o_word   (w_rd_word)
    );

    // All outputs decode directly from registers, so reset clears them at once.
    assign axi_awaddr  = r_addr;
    assign axi_awlen   = 4'(BURST_LEN - 1);
    assign axi_awvalid = (r_state == ST_WR_ADDR);
    assign axi_wdata   = {WORDS{w_wr_word}};
    assign axi_wstrb   = {(DATA_W/8){1'b1}};
    assign axi_wvalid  = (r_state == ST_WR_DATA);
    assign axi_wlast   = (r_state == ST_WR_DATA) && w_last_beat;
    assign axi_araddr  = r_addr;
    assign axi_arlen   = 4'(BURST_LEN - 1);
    assign axi_arvalid = (r_state == ST_RD_ADDR);
    assign o_busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign o_done      = (r_state == ST_DONE);
    assign o_err_flag  = r_err_flag;
    assign o_err_cnt   = r_err_cnt;
    assign o_iter_cnt  = r_iter_cnt;

endmodule

// File: tb/tb_ddr_axi_traffic_gen.sv
// Self-checking bench: reference model pushes expected AW/AR addresses and
// write words into queues; a slave/monitor process pops and compares on every
// handshake while serving a burst-slot memory for read-back.
module tb_ddr_axi_traffic_gen;

    localparam int          AW   = 28;
    localparam int          DW   = 256;
    localparam int          BL   = 16;
    localparam int          STEP = 128;
    localparam logic [27:0] SA   = 28'h000_0000;
    localparam logic [27:0] EA   = 28'h000_0180;
    localparam int          NB   = 4;

    logic            core_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic            ddr_init_done = 1'b1;
    logic            i_start = 1'b0;
    logic            i_pat_sel = 1'b0;
    logic            i_loop_en = 1'b0;
    logic [AW-1:0]   axi_awaddr;
    logic [3:0]      axi_awlen;
    logic            axi_awvalid;
    logic            axi_awready = 1'b0;
    logic [DW-1:0]   axi_wdata;
    logic [DW/8-1:0] axi_wstrb;
    logic            axi_wvalid;
    logic            axi_wlast;
    logic            axi_wready = 1'b0;
    logic [AW-1:0]   axi_araddr;
    logic [3:0]      axi_arlen;
    logic            axi_arvalid;
    logic            axi_arready = 1'b0;
    logic [DW-1:0]   axi_rdata = '0;
    logic            axi_rvalid = 1'b0;
    logic            axi_rlast = 1'b0;
    logic            o_busy;
    logic            o_done;
    logic            o_err_flag;
    logic [15:0]     o_err_cnt;
    logic [15:0]     o_iter_cnt;

    ddr_axi_traffic_gen #(
        .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .ADDR_STEP(STEP),
        .START_ADDR(SA), .END_ADDR(EA)
    ) dut (
        .core_clk(core_clk), .i_rst_n(i_rst_n), .ddr_init_done(ddr_init_done),
        .i_start(i_start), .i_pat_sel(i_pat_sel), .i_loop_en(i_loop_en),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wvalid(axi_wvalid), .axi_wlast(axi_wlast), .axi_wready(axi_wready),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid),
        .axi_rlast(axi_rlast), .o_busy(o_busy), .o_done(o_done),
        .o_err_flag(o_err_flag), .o_err_cnt(o_err_cnt), .o_iter_cnt(o_iter_cnt)
    );

    always #5 core_clk = ~core_clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_aw[$];
    logic [31:0] exp_ar[$];
    logic [31:0] exp_w[$];
    logic [DW-1:0] mem [logic [31:0]];
    logic [27:0] rq[$];

    bit stall_en = 1'b0;
    bit corrupt_en = 1'b0;
    bit sb_en = 1'b1;
    bit flag_chk = 1'b0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0, rburst = 0;
    int rbeat = 0, wbeat = 0;
    logic [27:0] cur_waddr = '0;
    logic [31:0] ew, key;
    logic [DW-1:0] rd;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference LFSR: x^32+x^22+x^2+x+1, shift right, feedback from bit 0.
    function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
        logic [31:0] t;
        t = s >> 1;
        if (s[0]) t = t ^ 32'h8020_0003;
        return t;
    endfunction

    // Expected traffic of n_it iterations starting at iteration first_it.
    task automatic push_run(input bit mode, input int first_it, input int n_it);
        logic [31:0] seed, w;
        for (int it = first_it; it < first_it + n_it; it++) begin
            seed = 32'hACE1_0000 + 32'(it);
            w = (mode && seed == 32'd0) ? 32'd1 : seed;
            for (int b = 0; b < NB; b++) begin
                exp_aw.push_back(32'(SA) + 32'(b * STEP));
                exp_ar.push_back(32'(SA) + 32'(b * STEP));
            end
            for (int k = 0; k < NB * BL; k++) begin
                if (mode) begin
                    exp_w.push_back(w);
                    w = ref_lfsr(w);
                end else begin
                    exp_w.push_back(seed + 32'(k));
                end
            end
        end
    endtask

    // Slave model and monitor: sets readies/read data for the next edge and
    // scores the handshakes that edge will complete.
    always @(negedge core_clk) begin
        if (!i_rst_n) begin
            axi_awready = 1'b0; axi_wready = 1'b0; axi_arready = 1'b0;
            axi_rvalid = 1'b0; axi_rlast = 1'b0;
            rq.delete(); rbeat = 0; flag_chk = 1'b0;
        end else begin
            if (flag_chk) begin
                flag_chk = 1'b0;
                chk("err_flag_after_bad_beat", o_err_flag, 1);
                chk("err_cnt_after_bad_beat", o_err_cnt, 1);
            end
            axi_awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (axi_awvalid && axi_awready) begin
                cur_waddr = axi_awaddr; wbeat = 0; aw_cnt++;
                if (sb_en) begin
                    chk("aw_expected", exp_aw.size() > 0, 1);
                    if (exp_aw.size() > 0) chk("awaddr", axi_awaddr, exp_aw.pop_front());
                    chk("awlen", axi_awlen, BL - 1);
                end
            end
            axi_wready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (axi_wvalid && axi_wready) begin
                mem[{cur_waddr, 4'(wbeat)}] = axi_wdata;
                if (sb_en) begin
                    chk("w_expected", exp_w.size() > 0, 1);
                    if (exp_w.size() > 0) begin
                        ew = exp_w.pop_front();
                        chk("wdata", axi_wdata, {8{ew}});
                    end
                    chk("wstrb", axi_wstrb, {(DW/8){1'b1}});
                    chk("wlast", axi_wlast, wbeat == BL - 1);
                end
                wbeat++; w_cnt++;
            end
            axi_rvalid = 1'b0; axi_rlast = 1'b0;
            if (rq.size() > 0 && (!stall_en || $urandom_range(0, 1) == 1)) begin
                key = {rq[0], 4'(rbeat)};
                rd = mem.exists(key) ? mem[key] : '0;
                if (corrupt_en && rburst == 2 && rbeat == 5) begin
                    rd[0] = ~rd[0];
                    chk("err_flag_before_bad_beat", o_err_flag, 0);
                    flag_chk = 1'b1;
                end
                axi_rdata = rd; axi_rvalid = 1'b1; axi_rlast = (rbeat == BL - 1);
                r_cnt++; rbeat++;
                if (rbeat == BL) begin
                    rbeat = 0; rburst++;
                    void'(rq.pop_front());
                end
            end
            axi_arready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (axi_arvalid && axi_arready) begin
                rq.push_back(axi_araddr); ar_cnt++;
                if (sb_en) begin
                    chk("ar_expected", exp_ar.size() > 0, 1);
                    if (exp_ar.size() > 0) chk("araddr", axi_araddr, exp_ar.pop_front());
                    chk("arlen", axi_arlen, BL - 1);
                end
            end
        end
    end

    task automatic clear_counts();
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0; rburst = 0;
    endtask

    task automatic pulse_start(input bit mode);
        @(negedge core_clk);
        i_pat_sel = mode; i_start = 1'b1;
        @(negedge core_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i = 0;
        while (!o_done && i < 20000) begin
            @(negedge core_clk);
            i++;
        end
        chk({tag, "_done"}, o_done, 1);
        chk({tag, "_busy"}, o_busy, 0);
    endtask

    task automatic check_end(input string tag, input int iters, input int errs);
        chk({tag, "_iter_cnt"}, o_iter_cnt, iters);
        chk({tag, "_err_cnt"}, o_err_cnt, errs);
        chk({tag, "_err_flag"}, o_err_flag, errs != 0);
        chk({tag, "_aw_cnt"}, aw_cnt, NB * iters);
        chk({tag, "_w_cnt"}, w_cnt, NB * BL * iters);
        chk({tag, "_ar_cnt"}, ar_cnt, NB * iters);
        chk({tag, "_r_cnt"}, r_cnt, NB * BL * iters);
        chk({tag, "_queues_drained"}, exp_aw.size() + exp_w.size() + exp_ar.size(), 0);
    endtask

    task automatic run_basic(input string tag, input bit mode, input bit stall,
                             input bit corrupt, input int errs);
        clear_counts();
        stall_en = stall; corrupt_en = corrupt;
        push_run(mode, 0, 1);
        pulse_start(mode);
        wait_done(tag);
        check_end(tag, 1, errs);
        corrupt_en = 1'b0; stall_en = 1'b0;
    endtask

    initial begin
        int n;
        bit any_valid, busy_ok;
        repeat (3) @(negedge core_clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_valids", {axi_awvalid, axi_wvalid, axi_arvalid}, 0);
        chk("rst_err", {o_err_flag, o_err_cnt}, 0);
        chk("rst_iter", o_iter_cnt, 0);
        chk("rst_addr", axi_awaddr, SA);
        i_rst_n = 1'b1;
        repeat (2) @(negedge core_clk);

        run_basic("incr", 1'b0, 1'b0, 1'b0, 0);
        run_basic("lfsr_stall", 1'b1, 1'b1, 1'b0, 0);
        run_basic("corrupt", 1'b0, 1'b1, 1'b1, 1);

        // Looping: three full iterations, loop disabled during the fourth write.
        clear_counts();
        push_run(1'b0, 0, 4);
        i_loop_en = 1'b1;
        pulse_start(1'b0);
        n = 0;
        while (o_iter_cnt != 16'd3 && n < 20000) begin @(negedge core_clk); n++; end
        chk("loop_reach_iter3", o_iter_cnt, 3);
        n = 0;
        while (!axi_wvalid && n < 1000) begin @(negedge core_clk); n++; end
        chk("loop_fourth_write_seen", axi_wvalid, 1);
        i_loop_en = 1'b0;
        wait_done("loop");
        check_end("loop", 4, 0);

        // Calibration held off: nothing may be issued while waiting.
        ddr_init_done = 1'b0;
        repeat (4) @(negedge core_clk);
        clear_counts();
        push_run(1'b0, 0, 1);
        pulse_start(1'b0);
        any_valid = 1'b0; busy_ok = 1'b1;
        repeat (1000) begin
            @(negedge core_clk);
            if (axi_awvalid || axi_wvalid || axi_arvalid) any_valid = 1'b1;
            if (!o_busy) busy_ok = 1'b0;
        end
        chk("init_wait_no_valid", any_valid, 0);
        chk("init_wait_busy", busy_ok, 1);
        ddr_init_done = 1'b1;
        n = 0;
        while (!axi_awvalid && n < 10) begin @(negedge core_clk); n++; end
        chk("init_to_awvalid_le4", n <= 4, 1);
        wait_done("init");
        check_end("init", 1, 0);

        // Reset in the middle of a write burst, then a clean rerun.
        clear_counts();
        push_run(1'b0, 0, 1);
        pulse_start(1'b0);
        n = 0;
        while (!axi_wvalid && n < 1000) begin @(negedge core_clk); n++; end
        chk("rst_mid_wvalid_seen", axi_wvalid, 1);
        repeat (3) @(negedge core_clk);
        sb_en = 1'b0;
        @(negedge core_clk);
        #1 i_rst_n = 1'b0;
        #1;
        chk("rst_mid_valids", {axi_awvalid, axi_wvalid, axi_arvalid}, 0);
        chk("rst_mid_busy", o_busy, 0);
        repeat (2) @(negedge core_clk);
        i_rst_n = 1'b1;
        exp_aw.delete(); exp_w.delete(); exp_ar.delete();
        @(negedge core_clk);
        sb_en = 1'b1;
        run_basic("rerun", 1'b0, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
